// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, defaults and address-field helpers for icache_dm
//
// Contents:
//   state_e        refill FSM state (IDLE, REFILL)
//   DEF_*          default parameter values
//   addr_offset    word offset within a line   = addr[OFF+1:2]
//   addr_index     line index                  = addr[OFF+IDX+1:OFF+2]
//   addr_tag       remaining upper bits         = addr[BITSIZE-1:OFF+IDX+2]
// The helpers work on a zero-extended 64-bit address. Callers size-cast the result.
package icache_pkg;

    localparam int unsigned DEF_BITSIZE = 32;
    localparam int unsigned DEF_N_LINES = 16;
    localparam int unsigned DEF_N_WORDS = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    function automatic logic [63:0] addr_offset(input logic [63:0] addr,
                                                input int unsigned off_w);
        return (addr >> 2) & ((64'd1 << off_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int unsigned off_w,
                                               input int unsigned idx_w);
        return (addr >> (off_w + 2)) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
        return addr >> (off_w + idx_w + 2);
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch-side and refill-side signal bundle of icache_dm
//
// CPU side : cpu_req_i, cpu_addr_i, cpu_ready_o, cpu_valid_o, cpu_data_o, flush_i
// Mem side : mem_req_o, mem_addr_o, mem_valid_i, mem_data_i
// Signal suffixes are seen from the cache. Modport slave is the cache,
// modport master is the fetch stage / memory that drives it.
interface icache_dm_if
    import icache_pkg::*;
#(
    parameter int unsigned BITSIZE = DEF_BITSIZE
);
    logic               cpu_req_i;
    logic [BITSIZE-1:0] cpu_addr_i;
    logic               cpu_ready_o;
    logic               cpu_valid_o;
    logic [BITSIZE-1:0] cpu_data_o;
    logic               flush_i;
    logic               mem_req_o;
    logic [BITSIZE-1:0] mem_addr_o;
    logic               mem_valid_i;
    logic [BITSIZE-1:0] mem_data_i;

    modport slave (
        input  cpu_req_i, cpu_addr_i, flush_i, mem_valid_i, mem_data_i,
        output cpu_ready_o, cpu_valid_o, cpu_data_o, mem_req_o, mem_addr_o
    );

    modport master (
        output cpu_req_i, cpu_addr_i, flush_i, mem_valid_i, mem_data_i,
        input  cpu_ready_o, cpu_valid_o, cpu_data_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data arrays of the direct-mapped cache
//
// Ports:
//   clk, rstn_i                   clock, async active-low reset (valid bits only)
//   rd_idx_i, rd_off_i            combinational lookup port
//   rd_valid_o, rd_tag_o, rd_data_o
//   wr_en_i, wr_idx_i, wr_off_i, wr_data_i   one data word write per cycle
//   tag_we_i, wr_tag_i            write tag of line wr_idx_i and mark it valid
//   flush_i                       clear every valid bit; wins over tag_we_i
// Tags and data are plain storage without reset.
module icache_line_store
    import icache_pkg::*;
#(
    parameter  int unsigned BITSIZE = DEF_BITSIZE,
    parameter  int unsigned N_LINES = DEF_N_LINES,
    parameter  int unsigned N_WORDS = DEF_N_WORDS,
    localparam int unsigned OFF_W   = $clog2(N_WORDS),
    localparam int unsigned IDX_W   = $clog2(N_LINES),
    localparam int unsigned TAG_W   = BITSIZE - OFF_W - IDX_W - 2
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    input  logic [OFF_W-1:0]   rd_off_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [BITSIZE-1:0] rd_data_o,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [OFF_W-1:0]   wr_off_i,
    input  logic [BITSIZE-1:0] wr_data_i,
    input  logic               tag_we_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic               flush_i
);

    logic [N_LINES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [N_LINES];
    logic [BITSIZE-1:0] data_q [N_LINES*N_WORDS];

    // A flush arriving on the refill's final edge also drops the new line.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (wr_en_i) begin
            data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache with word-by-word line refill
//
// Ports:
//   clk      clock, rising edge
//   rstn_i   async active-low reset
//   bus      icache_dm_if.slave: CPU fetch port (req/addr/ready/valid/data/flush)
//            and memory refill port (req/addr/valid/data)
// Build option ICACHE_CRITICAL_WORD_FIRST_EN: refill starts at the requested
// word and wraps; the CPU response follows the critical word. Without it the
// refill starts at word 0 and the response follows the last word.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned BITSIZE = DEF_BITSIZE,
    parameter int unsigned N_LINES = DEF_N_LINES,
    parameter int unsigned N_WORDS = DEF_N_WORDS
) (
    input logic        clk,
    input logic        rstn_i,
    icache_dm_if.slave bus
);

    localparam int unsigned OFF_W = $clog2(N_WORDS);
    localparam int unsigned IDX_W = $clog2(N_LINES);
    localparam int unsigned TAG_W = BITSIZE - OFF_W - IDX_W - 2;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   lidx_q, lidx_d;
    logic [TAG_W-1:0]   ltag_q, ltag_d;
    logic [OFF_W-1:0]   loff_q, loff_d;
    logic               cpu_valid_q, cpu_valid_d;
    logic [BITSIZE-1:0] cpu_data_q, cpu_data_d;
    logic               flush_pend_q, flush_pend_d;

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [BITSIZE-1:0] rd_data;
    logic               hit;
    logic [OFF_W-1:0]   cnt_inc;
    logic [OFF_W-1:0]   refill_start;
    logic               wr_en;
    logic               tag_we;
    logic               store_flush;
    logic               cpu_ready;
    logic               mem_req;
    logic [BITSIZE-1:0] mem_addr;

    assign req_off = OFF_W'(addr_offset(64'(bus.cpu_addr_i), OFF_W));
    assign req_idx = IDX_W'(addr_index(64'(bus.cpu_addr_i), OFF_W, IDX_W));
    assign req_tag = TAG_W'(addr_tag(64'(bus.cpu_addr_i), OFF_W, IDX_W));

    icache_line_store #(
        .BITSIZE (BITSIZE),
        .N_LINES (N_LINES),
        .N_WORDS (N_WORDS)
    ) u_store (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .rd_idx_i   (req_idx),
        .rd_off_i   (req_off),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (lidx_q),
        .wr_off_i   (cnt_q),
        .wr_data_i  (bus.mem_data_i),
        .tag_we_i   (tag_we),
        .wr_tag_i   (ltag_q),
        .flush_i    (store_flush)
    );

    assign hit     = rd_valid && (rd_tag == req_tag);
    assign cnt_inc = cnt_q + OFF_W'(1);
    // The line is complete once the counter would wrap back to where it began.
    assign refill_start = CWF ? loff_q : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lidx_d       = lidx_q;
        ltag_d       = ltag_q;
        loff_d       = loff_q;
        cpu_valid_d  = 1'b0;
        cpu_data_d   = cpu_data_q;
        flush_pend_d = flush_pend_q;
        wr_en        = 1'b0;
        tag_we       = 1'b0;
        store_flush  = 1'b0;
        cpu_ready    = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;

        case (state_q)
            IDLE: begin
                cpu_ready   = !bus.flush_i;
                store_flush = bus.flush_i;
                if (bus.cpu_req_i && cpu_ready) begin
                    if (hit) begin
                        cpu_valid_d = 1'b1;
                        cpu_data_d  = rd_data;
                    end else begin
                        state_d      = REFILL;
                        lidx_d       = req_idx;
                        ltag_d       = req_tag;
                        loff_d       = req_off;
                        cnt_d        = CWF ? req_off : '0;
                        flush_pend_d = 1'b0;
                    end
                end
            end

            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {ltag_q, lidx_q, cnt_q, 2'b00};
                if (bus.flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.mem_valid_i) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_inc;
                    if (cnt_q == loff_q) begin
                        cpu_data_d = bus.mem_data_i;
                        if (CWF) begin
                            cpu_valid_d = 1'b1;
                        end
                    end
                    if (cnt_inc == refill_start) begin
                        tag_we       = 1'b1;
                        state_d      = IDLE;
                        store_flush  = flush_pend_q || bus.flush_i;
                        flush_pend_d = 1'b0;
                        if (!CWF) begin
                            cpu_valid_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lidx_q       <= '0;
            ltag_q       <= '0;
            loff_q       <= '0;
            cpu_valid_q  <= 1'b0;
            cpu_data_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lidx_q       <= lidx_d;
            ltag_q       <= ltag_d;
            loff_q       <= loff_d;
            cpu_valid_q  <= cpu_valid_d;
            cpu_data_q   <= cpu_data_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus.cpu_ready_o = cpu_ready;
    assign bus.cpu_valid_o = cpu_valid_q;
    assign bus.cpu_data_o  = cpu_data_q;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = mem_addr;

endmodule

// File: doc/icache_dm.md
# icache_dm

Parametrised direct-mapped instruction cache for the core's fetch path, the multi-line successor of the single-line cache store. It sits between the IF stage (CPU port) and the instruction memory/bus (memory port). Hits return in one cycle and can issue back-to-back. Misses refill one full line word-by-word from memory, then validate the line and answer the fetch.

## Interface
- BITSIZE, 32, data and address width in bits.
- N_LINES, 16, number of lines; power of two, at least 2.
- N_WORDS, 4, words per line; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous assert, active-low.
- cpu_req_i  in  1  fetch request.
- cpu_addr_i  in  BITSIZE  byte address; bits [1:0] ignored.
- cpu_ready_o  out  1  cache can accept a request this cycle.
- cpu_valid_o  out  1  single-cycle pulse: cpu_data_o is valid.
- cpu_data_o  out  BITSIZE  fetched word.
- flush_i  in  1  invalidate all lines.
- mem_req_o  out  1  refill word request, held while refilling.
- mem_addr_o  out  BITSIZE  word-aligned refill address.
- mem_valid_i  in  1  mem_data_i carries the requested word.
- mem_data_i  in  BITSIZE  refill data.

## Operation
- Address split, with OFF = log2(N_WORDS) and IDX = log2(N_LINES):
  - offset = addr[OFF+1:2]
  - index = addr[OFF+IDX+1:OFF+2]
  - tag = remaining upper bits.
- Storage: per line one valid bit, one tag and N_WORDS data words. All valid bits are cleared by reset and by flush. Data and tags are not reset.
- FSM states are IDLE and REFILL.
- IDLE:
  - cpu_ready_o = !flush_i.
  - A request is accepted when cpu_req_i && cpu_ready_o; the address is latched.
  - Tag compare is combinational on cpu_addr_i.
  - Hit: register the word; cpu_valid_o pulses next cycle; stay in IDLE.
  - Miss: go to REFILL; clear the word counter to the line start.
- REFILL:
  - cpu_ready_o = 0 and mem_req_o = 1.
  - mem_addr_o = {latched tag, latched index, counter, 2'b00}.
  - Each mem_valid_i writes mem_data_i into line[index][counter]; the counter increments modulo N_WORDS.
  - When the counter value equals the requested offset, the word is also registered for the CPU.
  - After the N_WORDS-th word: set valid, write the tag, and return to IDLE.
- Memory protocol:
  - mem_valid_i is honoured only while mem_req_o = 1.
  - Any number of wait cycles is allowed.
  - mem_addr_o advances the cycle after each mem_valid_i.
- Flush:
  - In IDLE, flush_i clears all valid bits at the next edge and blocks acceptance that cycle.
  - During REFILL, flush_i sets a pending flag. The refill completes and its response is delivered. Then all valid bits, including the new line, are cleared on the edge the FSM re-enters IDLE.
- A new request is never accepted on the edge that ends a refill.
- Asynchronous reset mid-refill aborts the refill:
  - FSM returns to IDLE.
  - Valid bits are cleared.
  - Pending flush is cleared.
  - Outputs return to reset values.

## Timing
- Reset values:
  - cpu_valid_o = 0, cpu_data_o = 0.
  - mem_req_o = 0, mem_addr_o = 0.
  - cpu_ready_o = 1, since FSM is IDLE (gated only by flush_i).
- Hit latency: accept in cycle N, cpu_valid_o in N+1.
- Back-to-back hits give one response per cycle.
- Miss latency with zero-wait memory: accept N; words arrive N+1..N+N_WORDS; cpu_valid_o at N+N_WORDS+1.
- cpu_ready_o is high again at N+N_WORDS+1.
- cpu_valid_o is never asserted for more than one cycle per accepted request.

## Configuration
- ICACHE_CRITICAL_WORD_FIRST_EN defined:
  - Refill starts at the requested offset and wraps.
  - cpu_valid_o pulses the cycle after the critical word arrives, i.e. N+2 with zero-wait memory.
  - The remaining words keep filling with cpu_ready_o low until the line completes.
- Not defined:
  - Refill always starts at offset 0.
  - The response follows the last word.

## Structure
- Package icache_pkg holds:
  - the FSM state typedef (IDLE, REFILL);
  - default parameter constants;
  - address-field helper functions (offset, index, tag extraction).
- Sub-module icache_line_store holds the valid/tag/data arrays, with:
  - one read port for lookup;
  - one word write port plus a tag/valid write for refill;
  - a flash-clear for flush.

## Test plan
Configuration for all scenarios: N_LINES=16, N_WORDS=4, zero-wait memory unless stated.
1. Cold miss at 0x0000_0104:
   - mem_addr_o = 0x100, 0x104, 0x108, 0x10C.
   - Memory returns 0xA0..0xA3.
   - cpu_data_o = 0xA1 with cpu_valid_o at N+5.
2. Hit after scenario 1, requests 0x10C then 0x100 in consecutive cycles:
   - 0xA3 and 0xA0 returned at N+1 and N+2.
   - mem_req_o stays 0.
3. Conflict:
   - 0x0000_0204 (same index) refills and replaces the line.
   - A following fetch of 0x104 misses again.
4. Flush:
   - flush_i with cpu_req_i in IDLE: request not accepted.
   - Next fetch of 0x108 misses.
   - flush_i during a refill: response still delivered, then the line is invalid.
5. Wait states:
   - mem_valid_i every third cycle.
   - mem_addr_o holds between valids.
   - Correct word returned.
6. Reset and critical word first:
   - rstn_i low after two refill words: all outputs return to reset values; 0x104 misses afterwards.
   - With ICACHE_CRITICAL_WORD_FIRST_EN, fetch of 0x108: mem_addr_o order 0x108, 0x10C, 0x100, 0x104; cpu_valid_o at N+2; cpu_ready_o low until N+5.
